// File: rtl/uart_rx_deserializer_if.sv
// Serial receive bundle between the UART state machine, the raw line and the word consumer.
// The slave side is the deserializer; the master side drives tick, state and line.
interface uart_rx_deserializer_if #(
  parameter int DATA_BITS = 8
);
  logic                 bclk;
  logic                 state;
  logic                 rxd;
  logic                 brk;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ferr;

  modport master (output bclk, output state, output rxd,
                  input  brk,  input  data,  input  valid, input ferr);
  modport slave  (input  bclk, input  state, input  rxd,
                  output brk,  output data,  output valid, output ferr);
endinterface

// File: rtl/uart_rx_deserializer.sv
// Times a UART frame from the oversample tick while the receive state machine is BUSY,
// samples start/data/stop bits at mid-bit and returns BREAK plus VALID/FERR.
//   state   | meaning
//   S_IDLE  | counters cleared, waiting for BUSY
//   S_START | counting half a bit to mid start bit
//   S_DATA  | sampling DATA_BITS bits, LSB first
//   S_STOP  | sampling stop bit, emitting result
//   S_DONE  | result given, waiting for IDLE
module uart_rx_deserializer #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input logic clk_i,
  input logic reset_i,
  uart_rx_deserializer_if.slave rx
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic                 rxd_meta_q, rxs_q;
  logic [2:0]           state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 brk_q, brk_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    brk_d   = 1'b0;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        tick_d = '0;
        bit_d  = '0;
        if (rx.state) state_d = S_START;
      end
      S_START: begin
        if (!rx.state) begin
          state_d = S_IDLE;
          tick_d  = '0;
        end else if (rx.bclk) begin
          if (tick_q == TICK_HALF) begin
            tick_d = '0;
            if (rxs_q) begin
              brk_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_DATA;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (!rx.state) begin
          state_d = S_IDLE;
          tick_d  = '0;
          bit_d   = '0;
        end else if (rx.bclk) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
            if (bit_q == BIT_LAST) begin
              bit_d   = '0;
              state_d = S_STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (!rx.state) begin
          state_d = S_IDLE;
          tick_d  = '0;
        end else if (rx.bclk) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            brk_d   = 1'b1;
            state_d = S_DONE;
            // A low stop bit leaves the last good word in place.
            if (rxs_q) begin
              valid_d = 1'b1;
              data_d  = shift_q;
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        tick_d = '0;
        bit_d  = '0;
        if (!rx.state) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rxd_meta_q <= 1'b1;
      rxs_q      <= 1'b1;
      state_q    <= S_IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      brk_q      <= 1'b0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rxd_meta_q <= rx.rxd;
      rxs_q      <= rxd_meta_q;
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      brk_q      <= brk_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
    end
  end

  assign rx.brk   = brk_q;
  assign rx.data  = data_q;
  assign rx.valid = valid_q;
  assign rx.ferr  = ferr_q;
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: a frame-level tick model predicts BREAK/VALID/FERR/DATA
// every cycle; literal checks after each scenario pin both the DUT and the model.
module tb_uart_rx_deserializer;
  localparam int DB = 8;
  localparam int OS = 16;

  logic clk = 1'b0;
  logic reset;
  logic bclk_en;
  int   checks = 0;
  int   errors = 0;
  int   fail_prints = 0;
  bit   run_cmp = 1'b0;

  uart_rx_deserializer_if #(.DATA_BITS(DB)) bus ();

  uart_rx_deserializer #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .rx      (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    int c;
    c = 0;
    bus.bclk = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      c = (c + 1) % 4;
      bus.bclk = bclk_en && (c == 0);
    end
  end

  // Frame model: ticks are counted from the cycle BUSY is first seen; samples fall at
  // OS/2 + k*OS ticks, k=0 start, 1..DB data, DB+1 stop.
  int          m_mode;
  int          m_t;
  logic        m_s1, m_s2;
  logic [DB-1:0] m_word;
  logic [DB-1:0] e_data;
  logic        e_brk, e_valid, e_ferr;

  always @(posedge clk) begin
    logic rxs;
    int   k;
    e_brk = 1'b0;
    e_valid = 1'b0;
    e_ferr = 1'b0;
    if (reset) begin
      m_s1 = 1'b1;
      m_s2 = 1'b1;
      m_mode = 0;
      m_t = 0;
      e_data = '0;
      m_word = '0;
    end else begin
      rxs = m_s2;
      case (m_mode)
        0: if (bus.state) begin m_mode = 1; m_t = 0; end
        1: begin
          if (!bus.state) m_mode = 0;
          else if (bus.bclk) begin
            m_t = m_t + 1;
            if (m_t == OS / 2) begin
              if (rxs) begin e_brk = 1'b1; m_mode = 2; end
            end else if (m_t > OS / 2 && ((m_t - OS / 2) % OS) == 0) begin
              k = (m_t - OS / 2) / OS;
              if (k <= DB) m_word[k-1] = rxs;
              else begin
                e_brk = 1'b1;
                m_mode = 2;
                if (rxs) begin e_valid = 1'b1; e_data = m_word; end
                else e_ferr = 1'b1;
              end
            end
          end
        end
        default: if (!bus.state) m_mode = 0;
      endcase
      m_s2 = m_s1;
      m_s1 = bus.rxd;
    end
  end

  int n_brk = 0, n_valid = 0, n_ferr = 0;

  always @(negedge clk) begin
    if (run_cmp) begin
      checks++;
      if (bus.brk !== e_brk || bus.valid !== e_valid || bus.ferr !== e_ferr || bus.data !== e_data) begin
        errors++;
        if (fail_prints < 20) begin
          fail_prints++;
          $display("FAIL cycle_model t=%0t brk/valid/ferr/data got %b/%b/%b/%h want %b/%b/%b/%h",
                   $time, bus.brk, bus.valid, bus.ferr, bus.data, e_brk, e_valid, e_ferr, e_data);
        end
      end
      if (bus.brk === 1'b1) n_brk++;
      if (bus.valid === 1'b1) n_valid++;
      if (bus.ferr === 1'b1) n_ferr++;
    end
  end

  task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic hold_ticks(input int n);
    int got, guard;
    got = 0;
    guard = 0;
    while (got < n) begin
      @(posedge clk);
      #2;
      guard++;
      if (bus.bclk) got++;
      if (guard > 200 * n + 200) begin
        checks++;
        errors++;
        $display("FAIL tick_timeout got %0d ticks want %0d", got, n);
        return;
      end
    end
  endtask

  task automatic send_frame(input logic [DB-1:0] b, input logic stop, input int abort_at, input int stall_at);
    bus.state = 1'b1;
    bus.rxd = 1'b0;
    hold_ticks(OS);
    for (int i = 0; i < DB; i++) begin
      if (i == abort_at) begin
        bus.state = 1'b0;
        bus.rxd = 1'b1;
        hold_ticks(4);
        return;
      end
      bus.rxd = b[i];
      if (i == stall_at) begin
        hold_ticks(6);
        bclk_en = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        bclk_en = 1'b1;
        hold_ticks(OS - 6);
      end else begin
        hold_ticks(OS);
      end
    end
    bus.rxd = stop;
    hold_ticks(OS);
    bus.rxd = 1'b1;
    hold_ticks(2);
    bus.state = 1'b0;
    hold_ticks(2);
  endtask

  initial begin
    int v0, b0, f0;
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, b0, f0;
    reset = 1'b1;
    bclk_en = 1'b1;
    bus.state = 1'b0;
    bus.rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    run_cmp = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    check_lit("reset_outputs", {bus.brk, bus.valid, bus.ferr, 21'd0, bus.data}, 32'd0);
    hold_ticks(4);

    v0 = n_valid; b0 = n_brk; f0 = n_ferr;
    send_frame(8'h55, 1'b1, -1, -1);
    check_lit("f55_valid_cnt", n_valid - v0, 1);
    check_lit("f55_brk_cnt", n_brk - b0, 1);
    check_lit("f55_ferr_cnt", n_ferr - f0, 0);
    check_lit("f55_data", bus.data, 32'h55);
    check_lit("f55_model_data", e_data, 32'h55);

    v0 = n_valid; f0 = n_ferr;
    send_frame(8'hFF, 1'b0, -1, -1);
    check_lit("ferr_cnt", n_ferr - f0, 1);
    check_lit("ferr_valid_cnt", n_valid - v0, 0);
    check_lit("ferr_data_kept", bus.data, 32'h55);

    send_frame(8'hA3, 1'b1, -1, -1);
    check_lit("fA3_data", bus.data, 32'hA3);

    v0 = n_valid; b0 = n_brk; f0 = n_ferr;
    bus.state = 1'b1;
    bus.rxd = 1'b0;
    hold_ticks(3);
    bus.rxd = 1'b1;
    hold_ticks(12);
    check_lit("glitch_brk_cnt", n_brk - b0, 1);
    check_lit("glitch_vf_cnt", (n_valid - v0) + (n_ferr - f0), 0);
    check_lit("glitch_data", bus.data, 32'hA3);
    bus.state = 1'b0;
    hold_ticks(2);

    v0 = n_valid; b0 = n_brk; f0 = n_ferr;
    send_frame(8'h96, 1'b1, 4, -1);
    check_lit("abort_pulses", (n_brk - b0) + (n_valid - v0) + (n_ferr - f0), 0);
    check_lit("abort_data", bus.data, 32'hA3);
    send_frame(8'h3C, 1'b1, -1, -1);
    check_lit("f3C_data", bus.data, 32'h3C);

    bus.state = 1'b1;
    bus.rxd = 1'b0;
    hold_ticks(OS + 2 * OS);
    reset = 1'b1;
    bus.state = 1'b0;
    bus.rxd = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_lit("midreset_outputs", {bus.brk, bus.valid, bus.ferr, 21'd0, bus.data}, 32'd0);
    hold_ticks(4);
    send_frame(8'h81, 1'b1, -1, -1);
    check_lit("f81_data", bus.data, 32'h81);

    v0 = n_valid;
    send_frame(8'h01, 1'b1, -1, -1);
    check_lit("f01_data", bus.data, 32'h01);
    send_frame(8'h80, 1'b1, -1, 3);
    check_lit("b2b_valid_cnt", n_valid - v0, 2);
    check_lit("f80_data", bus.data, 32'h80);

    run_cmp = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
